alu_operand_stage: RTL
======================

# alu_operand_stage

Operand staging register for the 16-bit ALU datapath. It collects two operands serially from the internal data bus (A first, then B) with a valid/ready handshake. It holds them stable on parallel outputs and presents them to the downstream bitwise logic units (NAND/AND/OR/XOR) under a valid/ack handshake. Operands never change while a pair is being offered.

## Interface
- WIDTH, 16, operand width in bits.
- CNT_W, 8, width of the issued-pair counter.

- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_data  in  WIDTH  operand word from data bus.
- bus_valid  in  1  bus_data holds a word this cycle.
- bus_ready  out  1  stage accepts a word this cycle.
- op_a  out  WIDTH  registered operand A.
- op_b  out  WIDTH  registered operand B.
- opnd_valid  out  1  op_a/op_b form a complete pair.
- opnd_ack  in  1  downstream consumed the pair.
- flush  in  1  synchronous abort; discard any partial or pending pair.
- busy  out  1  stage is not idle.
- issue_cnt  out  CNT_W  count of pairs acknowledged since reset.

## Operation
- FSM states: IDLE (expecting A), GOT_A (expecting B), ISSUE (pair offered). Encoding is implementer's choice; state is held in registers only.
- Accept event: bus_valid && bus_ready at a rising edge.
- IDLE + accept: op_a <= bus_data, next state GOT_A.
- GOT_A + accept: op_b <= bus_data, next state ISSUE.
- ISSUE + opnd_ack: issue_cnt <= issue_cnt + 1 (modulo 2^CNT_W, 255 wraps to 0), next state IDLE.
- Outputs decoded from state (Moore):
  - bus_ready = 1 in IDLE and GOT_A; 0 in ISSUE.
  - opnd_valid = 1 only in ISSUE.
  - busy = 1 in GOT_A and ISSUE.
- op_a and op_b change only on their own accept or on flush. Both are stable throughout ISSUE.
- opnd_ack outside ISSUE is ignored: no count, no state change.
- bus_valid in ISSUE is ignored because bus_ready = 0. The bus master must hold the word.
- flush has priority over every other event in every state:
  - next state IDLE;
  - op_a and op_b cleared to 0;
  - issue_cnt unchanged, even if opnd_ack is high in the same cycle.
- No arithmetic on operands. Data passes bit-exact with no width change.

## Timing
- Reset (rst_n low, asynchronous, takes effect without waiting for clk):
  - state IDLE;
  - op_a = op_b = 0, issue_cnt = 0;
  - opnd_valid = 0, busy = 0, bus_ready = 1 (after deassertion).
- Reset mid-operation discards any partial or offered pair.
- Latency, back-to-back timing:
  - A accepted at edge n; B accepted at edge n+1.
  - opnd_valid high from just after edge n+1.
  - Earliest ack at edge n+2; IDLE after edge n+2.
  - Maximum throughput is one pair per 3 cycles.
- Stalls:
  - bus_valid gaps stall IDLE/GOT_A indefinitely.
  - opnd_ack low holds ISSUE indefinitely, with op_a, op_b and opnd_valid stable.
- bus_ready and opnd_valid carry no combinational path from any input.

## Test plan
- Reset, then A=0xFFFF, B=0x0F0F on consecutive cycles:
  - opnd_valid rises one edge after the B accept, with op_a=0xFFFF and op_b=0x0F0F;
  - the downstream NAND output reads 0xF0F0;
  - ack returns to IDLE and issue_cnt=1.
- Hold opnd_ack low for 10 cycles while bus_valid=1 with bus_data=0x1234:
  - bus_ready stays 0 and op_a/op_b are unchanged;
  - after ack, the next accept loads op_a=0x1234.
- Accept A=0xAAAA, then assert flush in GOT_A:
  - next cycle IDLE, op_a=0, busy=0;
  - the next two words form a fresh pair, and issue_cnt is unchanged.
- Assert flush and opnd_ack together in ISSUE: state IDLE, issue_cnt unchanged, operands 0.
- Run 256 complete pairs: issue_cnt wraps to 0. A stray opnd_ack pulse in IDLE does not change the count.
- Drive rst_n low asynchronously between clock edges while in ISSUE:
  - all outputs go to reset values immediately;
  - after release, a normal pair completes.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// Operand staging bus: serial word input from the data bus (valid/ready),
// parallel operand pair output to the logic units (valid/ack), plus control.
interface alu_operand_stage_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] bus_data;
    logic             bus_valid;
    logic             bus_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             opnd_valid;
    logic             opnd_ack;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] issue_cnt;

    modport master (
        output bus_data,
        output bus_valid,
        input  bus_ready,
        input  op_a,
        input  op_b,
        input  opnd_valid,
        output opnd_ack,
        output flush,
        input  busy,
        input  issue_cnt
    );

    modport slave (
        input  bus_data,
        input  bus_valid,
        output bus_ready,
        output op_a,
        output op_b,
        output opnd_valid,
        input  opnd_ack,
        input  flush,
        output busy,
        output issue_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand staging register: collects A then B from the bus and offers the pair.
// Ports: clk, rst_n (async active-low), io (slave side of alu_operand_stage_if).
module alu_operand_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_operand_stage_if.slave io
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        // flush beats every other event, including a same-cycle ack
        if (io.flush) begin
            state_d = IDLE;
            op_a_d  = '0;
            op_b_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io.bus_valid) begin
                        op_a_d  = io.bus_data;
                        state_d = GOT_A;
                    end
                end
                GOT_A: begin
                    if (io.bus_valid) begin
                        op_b_d  = io.bus_data;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (io.opnd_ack) begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs: decoded from state only, no path from any input
    assign io.bus_ready  = (state_q != ISSUE);
    assign io.opnd_valid = (state_q == ISSUE);
    assign io.busy       = (state_q != IDLE);
    assign io.op_a       = op_a_q;
    assign io.op_b       = op_b_q;
    assign io.issue_cnt  = cnt_q;

endmodule
